// File: rtl/conv_window_scan_engine.sv
// Sliding-window scan engine: walks an OUT_DIM x OUT_DIM grid of WIN x WIN windows over a
// binary fmap, feeds each window to a combinational core and streams the results out.
module conv_window_scan_engine #(
  parameter int IMG_DIM = 12,
  parameter int IN_CH   = 18,
  parameter int OUT_CH  = 60,
  parameter int WIN     = 6,
  parameter int STRIDE  = 2,
  localparam int OUT_DIM = (IMG_DIM - WIN) / STRIDE + 1,
  localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  input  logic [IMG_DIM*IMG_DIM*IN_CH-1:0] image,
  output logic [WIN*WIN*IN_CH-1:0]         win_data,
  input  logic [OUT_CH-1:0]                core_pixel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CW-1:0]                    out_row,
  output logic [CW-1:0]                    out_col,
  output logic [OUT_CH-1:0]                out_pixel
);

  localparam int IDX_W = (IMG_DIM * IMG_DIM * IN_CH > 1) ? $clog2(IMG_DIM * IMG_DIM * IN_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                out_valid_q, out_valid_d;
  logic [CW-1:0]       out_row_q, out_row_d;
  logic [CW-1:0]       out_col_q, out_col_d;
  logic [OUT_CH-1:0]   out_pixel_q, out_pixel_d;
  logic                done_q, done_d;
  logic                slot_free;
  logic [IDX_W-1:0]    img_idx;

  // Handshake: a beat transfers on any clock edge where out_valid && out_ready; while
  // out_valid is high and out_ready low the payload is frozen. The single output register
  // may be refilled in the same cycle its current beat is taken.
  assign slot_free = !out_valid_q || out_ready;

  // Channel-major window extraction for the current (row, col).
  always_comb begin
    win_data = '0;
    img_idx  = '0;
    for (int ch = 0; ch < IN_CH; ch++) begin
      for (int x = 0; x < WIN; x++) begin
        for (int y = 0; y < WIN; y++) begin
          img_idx = IDX_W'(((int'(row_q) * STRIDE + x) * IMG_DIM
                            + int'(col_q) * STRIDE + y) * IN_CH + ch);
          win_data[(ch * WIN + x) * WIN + y] = image[img_idx];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_pixel_d = out_pixel_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      row_d       = '0;
      col_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SCAN;
            row_d   = '0;
            col_d   = '0;
          end
        end
        SCAN: begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_row_d   = row_q;
            out_col_d   = col_q;
            out_pixel_d = core_pixel;
            // Counters freeze on the last window so win_data keeps pointing at it.
            if (row_q == LAST && col_q == LAST) begin
              state_d = DRAIN;
            end else if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_pixel_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_pixel_q <= out_pixel_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_pixel = out_pixel_q;

endmodule
